// File: rtl/ahb_pkg.sv
// Shared AHB encodings and helpers for the SRAM subsystem (arbiter and slave).
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HBURST encodings
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Address/control phase of one master, muxed as a unit
    typedef struct packed {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hburst;
        logic [2:0]  hsize;
    } ahb_ctrl_t;

    // Beats in a burst; 0 means unbounded (INCR)
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        logic [4:0] len;
        unique case (hburst)
            HBURST_SINGLE:               len = 5'd1;
            HBURST_INCR:                 len = 5'd0;
            HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
            default:                     len = 5'd16;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Tracks the burst in progress on the slave address phase: remaining beats of
// fixed-length bursts and accepted beats of unbounded INCR bursts.
module ahb_burst_tracker
    import ahb_pkg::*;
#(
    parameter int INCR_LIMIT = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       i_hready,
    input  logic [1:0] i_htrans,
    input  logic [2:0] i_hburst,
    output logic       o_last_beat,
    output logic       o_incr_limit_hit
);

    localparam int CNT_W = $clog2(INCR_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(INCR_LIMIT);

    logic [3:0]       r_beats_left;
    logic [CNT_W-1:0] r_incr_cnt;

    logic [4:0]       w_len;
    logic             w_nonseq;
    logic             w_seq;
    logic             w_idle;
    logic             w_is_incr;
    logic [3:0]       w_load_beats;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_len     = burst_len(i_hburst);
    assign w_nonseq  = i_hready && (i_htrans == HTRANS_NONSEQ);
    assign w_seq     = i_hready && (i_htrans == HTRANS_SEQ);
    assign w_idle    = i_hready && (i_htrans == HTRANS_IDLE);
    assign w_is_incr = (i_hburst == HBURST_INCR);

    // Beats still to come after a NONSEQ; SINGLE and INCR both load zero
    assign w_load_beats = (w_len == 5'd0) ? 4'd0 : 4'(w_len - 5'd1);

    // Saturating beat count of an INCR burst
    assign w_cnt_inc = (r_incr_cnt >= LIMIT) ? LIMIT : r_incr_cnt + CNT_W'(1);

    // The beat accepted this edge completes a SINGLE or fixed-length burst
    assign o_last_beat = (w_nonseq && (w_len == 5'd1)) ||
                         (w_seq && !w_is_incr && (r_beats_left <= 4'd1));

    // The beat accepted this edge brings an INCR burst up to the cap
    assign o_incr_limit_hit = w_seq && w_is_incr && (w_cnt_inc == LIMIT);

    // Burst counters advance only on accepted beats; IDLE abandons the burst
    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: state is written with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!HRESETn) begin
            r_beats_left <= 4'd0;
            r_incr_cnt   <= '0;
        end else if (w_nonseq) begin
            r_beats_left <= w_load_beats;
            r_incr_cnt   <= w_is_incr ? CNT_W'(1) : '0;
        end else if (w_seq) begin
            if (r_beats_left != 4'd0) begin
                r_beats_left <= r_beats_left - 4'd1;
            end
            if (w_is_incr) begin
                r_incr_cnt <= w_cnt_inc;
            end
        end else if (w_idle) begin
            r_beats_left <= 4'd0;
            r_incr_cnt   <= '0;
        end
    end

endmodule

// File: rtl/ahb_sram_arbiter.sv
// Two-master AHB arbiter and bus mux in front of the single-port SRAM slave.
// Round-robin grant, held across fixed bursts and locked sequences, with a cap
// on unlocked INCR bursts. Address phase follows addr_owner, HWDATA follows
// data_owner, both advancing only when the slave is ready.
module ahb_sram_arbiter
    import ahb_pkg::*;
#(
    parameter int PARK_MASTER = 0,
    parameter int INCR_LIMIT  = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    // master 0
    input  logic        m0_hbusreq,
    input  logic        m0_hlock,
    input  logic [31:0] m0_haddr,
    input  logic [1:0]  m0_htrans,
    input  logic        m0_hwrite,
    input  logic [2:0]  m0_hburst,
    input  logic [2:0]  m0_hsize,
    input  logic [31:0] m0_hwdata,
    output logic        m0_hgrant,
    output logic        m0_hready,
    output logic [31:0] m0_hrdata,
    output logic        m0_hresp,
    // master 1
    input  logic        m1_hbusreq,
    input  logic        m1_hlock,
    input  logic [31:0] m1_haddr,
    input  logic [1:0]  m1_htrans,
    input  logic        m1_hwrite,
    input  logic [2:0]  m1_hburst,
    input  logic [2:0]  m1_hsize,
    input  logic [31:0] m1_hwdata,
    output logic        m1_hgrant,
    output logic        m1_hready,
    output logic [31:0] m1_hrdata,
    output logic        m1_hresp,
    // slave
    output logic [31:0] s_haddr,
    output logic [1:0]  s_htrans,
    output logic        s_hwrite,
    output logic [2:0]  s_hburst,
    output logic [2:0]  s_hsize,
    output logic [31:0] s_hwdata,
    output logic        s_hmastlock,
    input  logic        s_hready,
    input  logic        s_hresp,
    input  logic [31:0] s_hrdata
);

    localparam logic PARK = (PARK_MASTER != 0);

    logic r_grant;
    logic r_addr_owner;
    logic r_data_owner;
    logic r_mastlock;

    ahb_ctrl_t w_m0_ctrl;
    ahb_ctrl_t w_m1_ctrl;
    ahb_ctrl_t w_addr_ctrl;
    logic [1:0] w_req;
    logic [1:0] w_lock;
    logic       w_owner_lock;
    logic       w_grant_lock;
    logic       w_owner_idle;
    logic       w_settled;
    logic       w_last_beat;
    logic       w_incr_limit_hit;
    logic       w_handover;
    logic       w_next_grant;

    assign w_m0_ctrl = '{haddr: m0_haddr, htrans: m0_htrans, hwrite: m0_hwrite,
                         hburst: m0_hburst, hsize: m0_hsize};
    assign w_m1_ctrl = '{haddr: m1_haddr, htrans: m1_htrans, hwrite: m1_hwrite,
                         hburst: m1_hburst, hsize: m1_hsize};

    assign w_req  = {m1_hbusreq, m0_hbusreq};
    assign w_lock = {m1_hlock, m0_hlock};

    // Address phase to the slave: only the address owner is ever forwarded
    assign w_addr_ctrl = r_addr_owner ? w_m1_ctrl : w_m0_ctrl;
    assign s_haddr     = w_addr_ctrl.haddr;
    assign s_htrans    = w_addr_ctrl.htrans;
    assign s_hwrite    = w_addr_ctrl.hwrite;
    assign s_hburst    = w_addr_ctrl.hburst;
    assign s_hsize     = w_addr_ctrl.hsize;
    assign s_hmastlock = r_mastlock;

    // Data phase lags the address phase by one accepted transfer
    assign s_hwdata = r_data_owner ? m1_hwdata : m0_hwdata;

    // Slave response is broadcast; each master qualifies it with its own state
    assign m0_hready = s_hready;
    assign m1_hready = s_hready;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;
    assign m0_hresp  = s_hresp;
    assign m1_hresp  = s_hresp;

    assign m0_hgrant = (r_grant == 1'b0);
    assign m1_hgrant = (r_grant == 1'b1);

    ahb_burst_tracker #(
        .INCR_LIMIT (INCR_LIMIT)
    ) u_burst_tracker (
        .HCLK             (HCLK),
        .HRESETn          (HRESETn),
        .i_hready         (s_hready),
        .i_htrans         (w_addr_ctrl.htrans),
        .i_hburst         (w_addr_ctrl.hburst),
        .o_last_beat      (w_last_beat),
        .o_incr_limit_hit (w_incr_limit_hit)
    );

    assign w_owner_lock = w_lock[r_addr_owner];
    assign w_grant_lock = w_lock[r_grant];
    assign w_owner_idle = (w_addr_ctrl.htrans == HTRANS_IDLE);

    // While the new grantee has not yet taken the address phase, the bubble
    // cycle's IDLE belongs to the old owner and must not trigger a handover.
    assign w_settled = (r_grant == r_addr_owner);

    assign w_handover = s_hready && w_settled && !w_owner_lock &&
                        (w_owner_idle || w_last_beat || w_incr_limit_hit);

    // Round-robin choice of the next grant on a handover edge
    always_comb begin
        // NOTE: the default assignment first keeps this purely combinational;
        // a path that skipped it would infer a latch.
        w_next_grant = r_grant;
        if (w_handover) begin
            if (w_req[~r_grant]) begin
                w_next_grant = ~r_grant;
            end else if (!w_req[r_grant]) begin
                w_next_grant = PARK;
            end
        end
    end

    // Grant and pipeline ownership advance together, frozen by wait states
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_grant      <= PARK;
            r_addr_owner <= PARK;
            r_data_owner <= PARK;
            r_mastlock   <= 1'b0;
        end else if (s_hready) begin
            r_grant      <= w_next_grant;
            r_addr_owner <= r_grant;
            r_data_owner <= r_addr_owner;
            r_mastlock   <= w_grant_lock;
        end
    end

endmodule
